// File: rtl/emif_arb_pkg.sv
// Shared types and constants for the EMIF / local dual-requester RAM arbiter.
// Optional per-side access counters are built when ARB_STATS_EN is defined.
package emif_arb_pkg;

    localparam int DATA_W      = 16;
    localparam int EMIF_ADDR_W = 24;
    localparam int CNT_W       = 16;

    localparam logic OWN_EMIF = 1'b0;
    localparam logic OWN_LOC  = 1'b1;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_EMIF,
        SRC_LOC
    } src_e;

    // Saturating increment for the access counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/arb_rd_tag_pipe.sv
// Owner-tagged read latency pipe: tracks RAM reads and steers returning data
// to the requester that issued them, RD_LAT+1 cycles after the RAM access.
module arb_rd_tag_pipe
    import emif_arb_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_vld,
    input  logic              i_own,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_emif_rdata,
    output logic              o_emif_rvalid,
    output logic [DATA_W-1:0] o_loc_rdata,
    output logic              o_loc_rvalid
);

    logic [RD_LAT-1:0] r_vld;
    logic [RD_LAT-1:0] r_own;
    logic              w_exit_emif;
    logic              w_exit_loc;

    // The last shift stage lines up with the cycle the RAM presents data.
    assign w_exit_emif = r_vld[RD_LAT-1] && (r_own[RD_LAT-1] == OWN_EMIF);
    assign w_exit_loc  = r_vld[RD_LAT-1] && (r_own[RD_LAT-1] == OWN_LOC);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld         <= '0;
            r_own         <= '0;
            o_emif_rvalid <= 1'b0;
            o_loc_rvalid  <= 1'b0;
            o_emif_rdata  <= '0;
            o_loc_rdata   <= '0;
        end else begin
            r_vld[0] <= i_vld;
            r_own[0] <= i_own;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_own[i] <= r_own[i-1];
            end
            o_emif_rvalid <= w_exit_emif;
            o_loc_rvalid  <= w_exit_loc;
            if (w_exit_emif) o_emif_rdata <= i_rdata;
            if (w_exit_loc)  o_loc_rdata  <= i_rdata;
        end
    end

endmodule

// File: rtl/emif_dpram_arbiter.sv
// Arbitrates one single-port RAM between the EMIF strobe stream (never stalled,
// always wins) and a local req/gnt requester. ARB_STATS_EN adds access counters.
module emif_dpram_arbiter
    import emif_arb_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 2
) (
    input  logic                   clk_100m,
    input  logic                   rst_n,
    input  logic                   emif_wen,
    input  logic                   emif_ren,
    input  logic [EMIF_ADDR_W-1:0] emif_addr,
    input  logic [DATA_W-1:0]      emif_wdata,
    output logic [DATA_W-1:0]      emif_rdata,
    output logic                   emif_rvalid,
    input  logic                   loc_req,
    input  logic                   loc_we,
    input  logic [ADDR_W-1:0]      loc_addr,
    input  logic [DATA_W-1:0]      loc_wdata,
    output logic                   loc_gnt,
    output logic [DATA_W-1:0]      loc_rdata,
    output logic                   loc_rvalid,
    output logic                   ram_en,
    output logic                   ram_we,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [DATA_W-1:0]      ram_wdata,
`ifdef ARB_STATS_EN
    input  logic                   stats_clr,
    output logic [CNT_W-1:0]       emif_acc_cnt,
    output logic [CNT_W-1:0]       loc_acc_cnt,
`endif
    input  logic [DATA_W-1:0]      ram_rdata
);

    logic              r_ren_d;
    logic              r_pend_vld;
    logic              r_pend_we;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [DATA_W-1:0] r_pend_wdata;
    logic              r_ram_own;
    logic              w_evt;
    logic              w_unused_addr;
    src_e              w_src;

    assign w_evt         = emif_wen | (emif_ren & ~r_ren_d);
    assign w_unused_addr = ^emif_addr[EMIF_ADDR_W-1:ADDR_W];

    // A fresh EMIF event also blocks the local side so the EMIF access
    // (issued next edge) is never reordered behind a local one.
    always_comb begin
        w_src = SRC_NONE;
        if (r_pend_vld)
            w_src = SRC_EMIF;
        else if (loc_req && !loc_gnt && !w_evt)
            w_src = SRC_LOC;
    end

    // Pending slot: drains every cycle it is full, so a refill never overflows.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_ren_d      <= 1'b0;
            r_pend_vld   <= 1'b0;
            r_pend_we    <= RD;
            r_pend_addr  <= '0;
            r_pend_wdata <= '0;
        end else begin
            r_ren_d <= emif_ren;
            if (w_evt) begin
                r_pend_vld   <= 1'b1;
                r_pend_we    <= emif_wen ? WR : RD;
                r_pend_addr  <= emif_addr[ADDR_W-1:0];
                r_pend_wdata <= emif_wdata;
            end else begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            r_ram_own <= OWN_EMIF;
            loc_gnt   <= 1'b0;
        end else begin
            ram_en  <= 1'b0;
            ram_we  <= 1'b0;
            loc_gnt <= 1'b0;
            case (w_src)
                SRC_EMIF: begin
                    ram_en    <= 1'b1;
                    ram_we    <= r_pend_we;
                    ram_addr  <= r_pend_addr;
                    ram_wdata <= r_pend_wdata;
                    r_ram_own <= OWN_EMIF;
                end
                SRC_LOC: begin
                    ram_en    <= 1'b1;
                    ram_we    <= loc_we;
                    ram_addr  <= loc_addr;
                    ram_wdata <= loc_wdata;
                    r_ram_own <= OWN_LOC;
                    loc_gnt   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    arb_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .i_clk         (clk_100m),
        .i_rst_n       (rst_n),
        .i_vld         (ram_en && (ram_we == RD)),
        .i_own         (r_ram_own),
        .i_rdata       (ram_rdata),
        .o_emif_rdata  (emif_rdata),
        .o_emif_rvalid (emif_rvalid),
        .o_loc_rdata   (loc_rdata),
        .o_loc_rvalid  (loc_rvalid)
    );

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] r_emif_cnt;
    logic [CNT_W-1:0] r_loc_cnt;

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_emif_cnt <= '0;
            r_loc_cnt  <= '0;
        end else if (stats_clr) begin
            r_emif_cnt <= '0;
            r_loc_cnt  <= '0;
        end else begin
            if (w_src == SRC_EMIF) r_emif_cnt <= sat_inc(r_emif_cnt);
            if (w_src == SRC_LOC)  r_loc_cnt  <= sat_inc(r_loc_cnt);
        end
    end

    assign emif_acc_cnt = r_emif_cnt;
    assign loc_acc_cnt  = r_loc_cnt;
`endif

endmodule

// File: tb/tb_emif_dpram_arbiter.sv
// Scoreboard bench for emif_dpram_arbiter: expected RAM accesses and read returns
// are queued at stimulus time and compared when the DUT produces them.
module tb_emif_dpram_arbiter;
    import emif_arb_pkg::*;

    localparam int ADDR_W = 12;
    localparam int RD_LAT = 2;

    logic               clk_100m = 1'b0;
    logic               rst_n    = 1'b0;
    logic               emif_wen = 1'b0;
    logic               emif_ren = 1'b0;
    logic [23:0]        emif_addr = '0;
    logic [15:0]        emif_wdata = '0;
    logic [15:0]        emif_rdata;
    logic               emif_rvalid;
    logic               loc_req = 1'b0;
    logic               loc_we = 1'b0;
    logic [ADDR_W-1:0]  loc_addr = '0;
    logic [15:0]        loc_wdata = '0;
    logic               loc_gnt;
    logic [15:0]        loc_rdata;
    logic               loc_rvalid;
    logic               ram_en;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_addr;
    logic [15:0]        ram_wdata;
    logic [15:0]        ram_rdata;
`ifdef ARB_STATS_EN
    logic               stats_clr = 1'b0;
    logic [15:0]        emif_acc_cnt;
    logic [15:0]        loc_acc_cnt;
`endif

    emif_dpram_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk_100m(clk_100m), .rst_n(rst_n),
        .emif_wen(emif_wen), .emif_ren(emif_ren), .emif_addr(emif_addr),
        .emif_wdata(emif_wdata), .emif_rdata(emif_rdata), .emif_rvalid(emif_rvalid),
        .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
        .loc_gnt(loc_gnt), .loc_rdata(loc_rdata), .loc_rvalid(loc_rvalid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
`ifdef ARB_STATS_EN
        .stats_clr(stats_clr), .emif_acc_cnt(emif_acc_cnt), .loc_acc_cnt(loc_acc_cnt),
`endif
        .ram_rdata(ram_rdata)
    );

    always #5 clk_100m = ~clk_100m;

    int cyc = 0;
    always @(posedge clk_100m) cyc <= cyc + 1;

    // RAM model with RD_LAT cycles from ram_en to valid ram_rdata.
    logic [15:0] mem [0:(1<<ADDR_W)-1];
    logic [15:0] rdp [RD_LAT];
    always @(posedge clk_100m) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        rdp[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) rdp[i] <= rdp[i-1];
    end
    assign ram_rdata = rdp[RD_LAT-1];

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       wdata;
        logic              own;
        logic [15:0]       rdata;
        int                at;
    } acc_t;
    typedef struct {
        logic [15:0] data;
        int          at;
    } rd_t;

    acc_t q_ram[$];
    rd_t  q_emif[$];
    rd_t  q_loc[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   sb_on = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_100m);
        #1;
    endtask

    task automatic push_acc(input logic we, input logic [ADDR_W-1:0] a, input logic [15:0] wd,
                            input logic own, input logic [15:0] rd, input int at);
        q_ram.push_back('{we, a, wd, own, rd, at});
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    logic [ADDR_W-1:0] last_addr = '0;
    logic [15:0]       last_wdata = '0;
    always @(negedge clk_100m) begin
        acc_t e;
        rd_t  r;
        if (!rst_n) begin
            q_emif.delete();
            q_loc.delete();
            last_addr  = '0;
            last_wdata = '0;
        end else if (sb_on) begin
            if (ram_en) begin
                if (q_ram.size() == 0) begin
                    chk("stray_ram_en", 1, 0);
                end else begin
                    e = q_ram.pop_front();
                    chk("ram_cyc", cyc, e.at);
                    chk("ram_we", ram_we, e.we);
                    chk("ram_addr", ram_addr, e.addr);
                    if (e.we) chk("ram_wdata", ram_wdata, e.wdata);
                    chk("loc_gnt", loc_gnt, e.own == OWN_LOC);
                    if (!e.we) begin
                        r = '{e.rdata, cyc + RD_LAT + 1};
                        if (e.own == OWN_LOC) q_loc.push_back(r);
                        else                  q_emif.push_back(r);
                    end
                end
                last_addr  = ram_addr;
                last_wdata = ram_wdata;
            end else begin
                chk("idle_we", ram_we, 0);
                chk("idle_addr_hold", {ram_addr, ram_wdata}, {last_addr, last_wdata});
                if (loc_gnt) chk("stray_gnt", 1, 0);
            end
            if (emif_rvalid) begin
                if (q_emif.size() == 0) chk("stray_emif_rvalid", 1, 0);
                else begin
                    r = q_emif.pop_front();
                    chk("emif_rvalid_cyc", cyc, r.at);
                    chk("emif_rdata", emif_rdata, r.data);
                end
            end
            if (loc_rvalid) begin
                if (q_loc.size() == 0) chk("stray_loc_rvalid", 1, 0);
                else begin
                    r = q_loc.pop_front();
                    chk("loc_rvalid_cyc", cyc, r.at);
                    chk("loc_rdata", loc_rdata, r.data);
                end
            end
        end
    end

    task automatic emif_wr(input logic [23:0] a, input logic [15:0] d);
        emif_wen = 1'b1; emif_addr = a; emif_wdata = d;
        push_acc(WR, a[ADDR_W-1:0], d, OWN_EMIF, 16'h0, cyc + 2);
        tick();
        emif_wen = 1'b0;
    endtask

    task automatic emif_rd(input logic [23:0] a, input logic [15:0] exp, input int hold);
        emif_ren = 1'b1; emif_addr = a;
        push_acc(RD, a[ADDR_W-1:0], 16'h0, OWN_EMIF, exp, cyc + 2);
        repeat (hold) tick();
        emif_ren = 1'b0;
    endtask

    task automatic wait_gnt(input string tag);
        int n;
        n = 0;
        tick();
        while (!loc_gnt && n < 20) begin
            tick();
            n++;
        end
        if (!loc_gnt) chk(tag, 0, 1);
    endtask

    // Local requester holds req and advances its payload after each grant.
    task automatic loc_run(input logic we, input int n);
        int s;
        s = cyc;
        loc_req = 1'b1;
        loc_we  = we;
        for (int i = 0; i < n; i++) begin
            loc_addr  = ADDR_W'(i);
            loc_wdata = 16'h5000 + 16'(i);
            push_acc(we, ADDR_W'(i), 16'h5000 + 16'(i), OWN_LOC, 16'h5000 + 16'(i), s + 1 + 2 * i);
            wait_gnt("loc_gnt_timeout");
        end
        loc_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_ram.size() + q_emif.size() + q_loc.size()) != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain", q_ram.size() + q_emif.size() + q_loc.size(), 0);
        repeat (3) tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_data", {emif_rdata, loc_rdata, ram_wdata}, 48'h0);
        chk("rst_ctrl", {emif_rvalid, loc_gnt, loc_rvalid, ram_en, ram_we, ram_addr}, 17'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        emif_wr(24'h000123, 16'hA55A);
        tick();
        drain();

        emif_wr(24'h000040, 16'h1234);
        tick();
        emif_rd(24'h000040, 16'h1234, 6);
        drain();

        // Upper EMIF address bits ignored; back-to-back strobes both issue.
        emif_wr(24'hFFF456, 16'hC0DE);
        emif_wr(24'hABC457, 16'hC0DF);
        tick();
        emif_rd(24'h123456, 16'hC0DE, 2);
        drain();

        // Write and read edge together: only the write survives.
        emif_wen = 1'b1; emif_ren = 1'b1; emif_addr = 24'h0000AB; emif_wdata = 16'h7777;
        push_acc(WR, 12'h0AB, 16'h7777, OWN_EMIF, 16'h0, cyc + 2);
        tick();
        emif_wen = 1'b0;
        repeat (2) tick();
        emif_ren = 1'b0;
        drain();

        // Collision: EMIF first, local one cycle later.
        emif_wen = 1'b1; emif_addr = 24'h000020; emif_wdata = 16'h1111;
        loc_req = 1'b1; loc_we = WR; loc_addr = 12'h010; loc_wdata = 16'hBEEF;
        push_acc(WR, 12'h020, 16'h1111, OWN_EMIF, 16'h0, cyc + 2);
        push_acc(WR, 12'h010, 16'hBEEF, OWN_LOC, 16'h0, cyc + 3);
        tick();
        emif_wen = 1'b0;
        wait_gnt("collision_gnt_timeout");
        loc_req = 1'b0;
        drain();

        loc_run(WR, 4);
        drain();
        loc_run(RD, 4);
        drain();

        // Reset one cycle after an EMIF read issues.
        emif_rd(24'h000040, 16'h1234, 1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_data", {emif_rdata, loc_rdata, ram_wdata}, 48'h0);
        chk("midrst_ctrl", {emif_rvalid, loc_gnt, loc_rvalid, ram_en, ram_we, ram_addr}, 17'h0);
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        emif_rd(24'h000040, 16'h1234, 3);
        drain();

`ifdef ARB_STATS_EN
        sb_on = 1'b0;
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        loc_req = 1'b1; loc_we = WR;
        begin
            int g;
            int n;
            g = 0;
            n = 0;
            while (g < 70000 && n < 150000) begin
                tick();
                n++;
                if (loc_gnt) g++;
            end
            chk("stats_run", g, 70000);
        end
        loc_req = 1'b0;
        repeat (2) tick();
        chk("loc_cnt_sat", loc_acc_cnt, 16'hFFFF);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("loc_cnt_clr", loc_acc_cnt, 16'h0);
        chk("emif_cnt_clr", emif_acc_cnt, 16'h0);
        loc_req = 1'b1; stats_clr = 1'b1;
        tick();
        loc_req = 1'b0; stats_clr = 1'b0;
        repeat (2) tick();
        chk("loc_cnt_clr_prio", loc_acc_cnt, 16'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
